// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS/CTRL bit positions, FSM state encoding and small helpers.
package uart_tx_pkg;

    // Word offsets inside the 16-byte register window
    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_BAUD   = 4'h8;
    localparam logic [3:0] OFF_CTRL   = 4'hC;

    // STATUS bit positions
    localparam int ST_BUSY_BIT  = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_EMPTY_BIT = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_CNT_LSB   = 4;

    // CTRL bit positions
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_OVFCLR_BIT = 1;
    localparam int CTRL_PAR_BIT    = 2;

    // Transmitter FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // STATUS only has four bits for the fill level, so larger counts clamp
    function automatic logic [3:0] sat_count4(input logic [7:0] cnt);
        return (cnt > 8'd15) ? 4'hF : cnt[3:0];
    endfunction

    // A programmed divisor of zero behaves like one cycle per bit
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous push/pop FIFO feeding the UART transmitter.
// A push while full is accepted only if a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped UART transmitter on the CPU data bus.
// Bytes written to TXDATA are queued in a FIFO and sent 8N1, LSB first.
// Build option: define UART_TX_PARITY_EN to add CTRL[2] even parity (8E1).
module bus_uart_tx
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_F100,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] Bus_addr,
    input  logic        Bus_we,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] Bus_rdata,
    output logic        uart_txd
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Bus decode
    logic        w_hit;
    logic [3:0]  w_off;
    logic        w_wr;
    logic        w_push_req;

    // FIFO interface
    logic        w_pop;
    logic [7:0]  w_fifo_rdata;
    logic        w_full;
    logic        w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]  w_count8;

    // Control/status registers
    logic [15:0] r_baud;
    logic        r_en;
    logic        r_ovf;

    // Transmitter state
    tx_state_t   r_state;
    logic        r_txd;
    logic [15:0] r_cnt;
    logic [15:0] r_div;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        w_bit_end;
    logic        w_busy;
    logic        w_unused;

`ifdef UART_TX_PARITY_EN
    logic        r_par_en;
    logic        r_frame_par;
    logic        r_par_bit;
`endif

    assign w_hit      = (Bus_addr[31:4] == BASE_ADDR[31:4]);
    assign w_off      = Bus_addr[3:0];
    assign w_wr       = Bus_we & w_hit;
    assign w_push_req = w_wr & (w_off == OFF_TXDATA);
    assign w_count8   = 8'(w_count);
    assign w_busy     = (r_state != ST_IDLE);
    assign w_bit_end  = (r_cnt == (r_div - 16'd1));
    assign uart_txd   = r_txd;
    assign w_unused   = ^Bus_wdata[31:16];

    // A byte is taken from the FIFO when idle, or at the very end of a stop
    // bit so the next start bit follows without an idle gap
    assign w_pop = r_en & ~w_empty &
                   ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_bit_end));

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk   (cpu_clk),
        .i_rst   (cpu_rst),
        .i_push  (w_push_req),
        .i_wdata (Bus_wdata[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Register writes: divisor, enable, sticky overflow (set wins over clear)
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_baud   <= DIV_RESET;
            r_en     <= 1'b0;
            r_ovf    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_en <= 1'b0;
`endif
        end else begin
            if (w_wr && (w_off == OFF_BAUD)) begin
                r_baud <= Bus_wdata[15:0];
            end
            if (w_wr && (w_off == OFF_CTRL)) begin
                r_en <= Bus_wdata[CTRL_EN_BIT];
                if (Bus_wdata[CTRL_OVFCLR_BIT]) begin
                    r_ovf <= 1'b0;
                end
`ifdef UART_TX_PARITY_EN
                r_par_en <= Bus_wdata[CTRL_PAR_BIT];
`endif
            end
            if (w_push_req && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Combinational read mux; zero outside the window and at unmapped offsets
    always_comb begin
        Bus_rdata = '0;
        if (w_hit) begin
            case (w_off)
                OFF_STATUS: begin
                    Bus_rdata[ST_BUSY_BIT]         = w_busy;
                    Bus_rdata[ST_FULL_BIT]         = w_full;
                    Bus_rdata[ST_EMPTY_BIT]        = w_empty;
                    Bus_rdata[ST_OVF_BIT]          = r_ovf;
                    Bus_rdata[ST_CNT_LSB +: 4]     = sat_count4(w_count8);
                end
                OFF_BAUD: begin
                    Bus_rdata[15:0] = r_baud;
                end
                OFF_CTRL: begin
                    Bus_rdata[CTRL_EN_BIT] = r_en;
`ifdef UART_TX_PARITY_EN
                    Bus_rdata[CTRL_PAR_BIT] = r_par_en;
`endif
                end
                default: Bus_rdata = '0;
            endcase
        end
    end

    // Serializer FSM: each symbol is held for r_div cycles, divisor latched at pop
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_state     <= ST_IDLE;
            r_txd       <= 1'b1;
            r_cnt       <= '0;
            r_div       <= 16'd1;
            r_bit_idx   <= '0;
            r_shift     <= '0;
`ifdef UART_TX_PARITY_EN
            r_frame_par <= 1'b0;
            r_par_bit   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        r_shift     <= w_fifo_rdata;
                        r_div       <= eff_div(r_baud);
                        r_cnt       <= '0;
                        r_txd       <= 1'b0;
                        r_state     <= ST_START;
`ifdef UART_TX_PARITY_EN
                        r_frame_par <= r_par_en;
                        r_par_bit   <= ^w_fifo_rdata;
`endif
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_txd     <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_state   <= ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            if (r_frame_par) begin
                                r_txd   <= r_par_bit;
                                r_state <= ST_PARITY;
                            end else begin
                                r_txd   <= 1'b1;
                                r_state <= ST_STOP;
                            end
`else
                            r_txd   <= 1'b1;
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_txd     <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_PARITY: begin
`ifdef UART_TX_PARITY_EN
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_txd   <= 1'b1;
                        r_state <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
`else
                    r_txd   <= 1'b1;
                    r_state <= ST_IDLE;
`endif
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_pop) begin
                            r_shift     <= w_fifo_rdata;
                            r_div       <= eff_div(r_baud);
                            r_txd       <= 1'b0;
                            r_state     <= ST_START;
`ifdef UART_TX_PARITY_EN
                            r_frame_par <= r_par_en;
                            r_par_bit   <= ^w_fifo_rdata;
`endif
                        end else begin
                            r_txd   <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: register access, serial framing,
// FIFO overflow, back-to-back frames, divisor handling and reset.
module tb_bus_uart_tx;

    localparam logic [31:0] BASE   = 32'hFFFF_F100;
    localparam logic [31:0] A_TX   = BASE + 32'h0;
    localparam logic [31:0] A_ST   = BASE + 32'h4;
    localparam logic [31:0] A_BAUD = BASE + 32'h8;
    localparam logic [31:0] A_CTRL = BASE + 32'hC;

    logic        cpu_clk   = 1'b0;
    logic        cpu_rst   = 1'b1;
    logic [31:0] Bus_addr  = 32'h0;
    logic        Bus_we    = 1'b0;
    logic [31:0] Bus_wdata = 32'h0;
    logic [31:0] Bus_rdata;
    logic        uart_txd;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected serial line, one entry per clock cycle
    logic exp_line[$];
    int   cap_bad;
    logic cap_obs;
    logic cap_exp;

    bus_uart_tx dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst   (cpu_rst),
        .Bus_addr  (Bus_addr),
        .Bus_we    (Bus_we),
        .Bus_wdata (Bus_wdata),
        .Bus_rdata (Bus_rdata),
        .uart_txd  (uart_txd)
    );

    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge cpu_clk);
        Bus_addr  = addr;
        Bus_wdata = data;
        Bus_we    = 1'b1;
        @(posedge cpu_clk);
        #1;
        Bus_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        Bus_addr = addr;
        #1;
        data = Bus_rdata;
    endtask

    // Reference framing: start, 8 data bits LSB first, optional even parity, stop
    task automatic add_frame(input logic [7:0] b, input int div, input bit par);
        int d;
        d = (div == 0) ? 1 : div;
        for (int k = 0; k < d; k++) exp_line.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < d; k++) exp_line.push_back(b[i]);
        if (par)
            for (int k = 0; k < d; k++) exp_line.push_back(^b);
        for (int k = 0; k < d; k++) exp_line.push_back(1'b1);
    endtask

    // Sample the line once per cycle against exp_line; remember first deviation
    task automatic capture_line(input bit wait_pop);
        cap_bad = -1;
        cap_obs = 1'b0;
        cap_exp = 1'b0;
        if (wait_pop) @(posedge cpu_clk);
        for (int i = 0; i < exp_line.size(); i++) begin
            @(negedge cpu_clk);
            if (cap_bad < 0 && uart_txd !== exp_line[i]) begin
                cap_bad = i;
                cap_obs = uart_txd;
                cap_exp = exp_line[i];
            end
        end
        exp_line.delete();
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        repeat (2) @(negedge cpu_clk);
        if (uart_txd !== 1'b1) $display("FAIL rst_txd: got %b want 1", uart_txd); else n_pass++;
        n_checks++;
        bus_read(A_ST, rd);
        if (rd !== 32'h4) $display("FAIL rst_status: got %h want 00000004", rd); else n_pass++;
        n_checks++;
        bus_read(A_BAUD, rd);
        if (rd !== 32'd434) $display("FAIL rst_baud: got %0d want 434", rd); else n_pass++;
        n_checks++;
        bus_read(A_CTRL, rd);
        if (rd !== 32'h0) $display("FAIL rst_ctrl: got %h want 0", rd); else n_pass++;
        n_checks++;
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        bus_read(A_TX, rd);
        if (rd !== 32'h0) $display("FAIL txdata_read: got %h want 0", rd); else n_pass++;
        n_checks++;
        bus_read(BASE + 32'h6, rd);
        if (rd !== 32'h0) $display("FAIL unmapped_read: got %h want 0", rd); else n_pass++;
        n_checks++;
        bus_read(BASE + 32'h18, rd);
        if (rd !== 32'h0) $display("FAIL miss_read: got %h want 0", rd); else n_pass++;
        n_checks++;
        bus_write(BASE + 32'h9, 32'h5);
        bus_write(BASE + 32'h18, 32'h7);
        bus_read(A_BAUD, rd);
        if (rd !== 32'd434) $display("FAIL ignored_writes: baud %0d want 434", rd); else n_pass++;
        n_checks++;
    endtask

    task automatic test_frame_a5();
        logic [31:0] rd;
        bus_write(A_BAUD, 32'd4);
        bus_write(A_CTRL, 32'h1);
        add_frame(8'hA5, 4, 1'b0);
        bus_write(A_TX, 32'hA5);
        capture_line(1'b1);
        if (cap_bad !== -1) $display("FAIL frame_a5: cycle %0d line %b want %b", cap_bad, cap_obs, cap_exp); else n_pass++;
        n_checks++;
        bus_read(A_ST, rd);
        if (rd[0] !== 1'b1) $display("FAIL a5_busy_in_stop: busy %b want 1", rd[0]); else n_pass++;
        n_checks++;
        @(negedge cpu_clk);
        bus_read(A_ST, rd);
        if (rd !== 32'h4) $display("FAIL a5_idle_after_40: status %h want 00000004", rd); else n_pass++;
        n_checks++;
        if (uart_txd !== 1'b1) $display("FAIL a5_line_idle: got %b want 1", uart_txd); else n_pass++;
        n_checks++;
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic [7:0]  fifo_q[$];
        logic [7:0]  b;
        bus_write(A_CTRL, 32'h0);
        bus_write(A_BAUD, 32'd2);
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            if (fifo_q.size() < 8) fifo_q.push_back(b);
            bus_write(A_TX, {24'h0, b});
        end
        bus_read(A_ST, rd);
        if (rd !== 32'h8A) $display("FAIL ovf_status: got %h want 0000008a", rd); else n_pass++;
        n_checks++;
        bus_write(A_CTRL, 32'h3);
        bus_read(A_ST, rd);
        if (rd !== 32'h82) $display("FAIL ovf_clear: got %h want 00000082", rd); else n_pass++;
        n_checks++;
        // Push lands on the same edge as the first pop while full
        b = 8'($urandom);
        fifo_q.push_back(b);
        bus_write(A_TX, {24'h0, b});
        bus_read(A_ST, rd);
        if (rd !== 32'h83) $display("FAIL push_pop_full: got %h want 00000083", rd); else n_pass++;
        n_checks++;
        while (fifo_q.size() > 0) add_frame(fifo_q.pop_front(), 2, 1'b0);
        capture_line(1'b0);
        if (cap_bad !== -1) $display("FAIL ovf_frames: cycle %0d line %b want %b", cap_bad, cap_obs, cap_exp); else n_pass++;
        n_checks++;
        @(negedge cpu_clk);
        bus_read(A_ST, rd);
        if (rd !== 32'h4) $display("FAIL ovf_drained: got %h want 00000004", rd); else n_pass++;
        n_checks++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        bus_write(A_CTRL, 32'h0);
        bus_write(A_BAUD, 32'd2);
        bus_write(A_TX, 32'h00);
        bus_write(A_TX, 32'hFF);
        add_frame(8'h00, 2, 1'b0);
        add_frame(8'hFF, 2, 1'b0);
        bus_write(A_CTRL, 32'h1);
        capture_line(1'b1);
        if (cap_bad !== -1) $display("FAIL back_to_back: cycle %0d line %b want %b", cap_bad, cap_obs, cap_exp); else n_pass++;
        n_checks++;
        @(negedge cpu_clk);
        bus_read(A_ST, rd);
        if (rd !== 32'h4) $display("FAIL b2b_idle: got %h want 00000004", rd); else n_pass++;
        n_checks++;
    endtask

    task automatic test_divisor();
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        b0 = 8'($urandom);
        bus_write(A_CTRL, 32'h0);
        bus_write(A_BAUD, 32'd0);
        bus_write(A_TX, {24'h0, b0});
        add_frame(b0, 0, 1'b0);
        bus_write(A_CTRL, 32'h1);
        capture_line(1'b1);
        if (cap_bad !== -1) $display("FAIL div0: cycle %0d line %b want %b", cap_bad, cap_obs, cap_exp); else n_pass++;
        n_checks++;
        @(negedge cpu_clk);
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        bus_write(A_CTRL, 32'h0);
        bus_write(A_BAUD, 32'd2);
        bus_write(A_TX, {24'h0, b1});
        bus_write(A_TX, {24'h0, b2});
        add_frame(b1, 2, 1'b0);
        add_frame(b2, 6, 1'b0);
        bus_write(A_CTRL, 32'h1);
        fork
            capture_line(1'b1);
            begin
                repeat (5) @(negedge cpu_clk);
                bus_write(A_BAUD, 32'd6);
            end
        join
        if (cap_bad !== -1) $display("FAIL div_change: cycle %0d line %b want %b", cap_bad, cap_obs, cap_exp); else n_pass++;
        n_checks++;
        @(negedge cpu_clk);
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic [7:0]  b;
        int          div;
        int          n;
        for (int it = 0; it < 4; it++) begin
            div = $urandom_range(1, 4);
            n   = $urandom_range(1, 3);
            bus_write(A_CTRL, 32'h0);
            bus_write(A_BAUD, 32'(div));
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                add_frame(b, div, 1'b0);
                bus_write(A_TX, {24'h0, b});
            end
            bus_write(A_CTRL, 32'h1);
            capture_line(1'b1);
            if (cap_bad !== -1) $display("FAIL random_%0d: div %0d cycle %0d line %b want %b", it, div, cap_bad, cap_obs, cap_exp); else n_pass++;
            n_checks++;
            @(negedge cpu_clk);
            bus_read(A_ST, rd);
            if (rd !== 32'h4) $display("FAIL random_idle_%0d: got %h want 00000004", it, rd); else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_parity();
        logic [31:0] rd;
`ifdef UART_TX_PARITY_EN
        bus_write(A_CTRL, 32'h4);
        bus_read(A_CTRL, rd);
        if (rd !== 32'h4) $display("FAIL ctrl_par_readback: got %h want 00000004", rd); else n_pass++;
        n_checks++;
        bus_write(A_BAUD, 32'd3);
        bus_write(A_TX, 32'h07);
        bus_write(A_TX, 32'h03);
        add_frame(8'h07, 3, 1'b1);
        add_frame(8'h03, 3, 1'b1);
        bus_write(A_CTRL, 32'h5);
        capture_line(1'b1);
        if (cap_bad !== -1) $display("FAIL parity_frames: cycle %0d line %b want %b", cap_bad, cap_obs, cap_exp); else n_pass++;
        n_checks++;
        @(negedge cpu_clk);
        bus_write(A_CTRL, 32'h0);
`else
        bus_write(A_CTRL, 32'h5);
        bus_read(A_CTRL, rd);
        if (rd !== 32'h1) $display("FAIL ctrl_no_parity: got %h want 00000001", rd); else n_pass++;
        n_checks++;
        bus_write(A_CTRL, 32'h0);
`endif
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        int          high_bad;
        bus_write(A_CTRL, 32'h0);
        bus_write(A_BAUD, 32'd4);
        bus_write(A_TX, 32'h00);
        bus_write(A_CTRL, 32'h1);
        @(posedge cpu_clk);
        repeat (6) @(negedge cpu_clk);
        if (uart_txd !== 1'b0) $display("FAIL mid_line_low: got %b want 0", uart_txd); else n_pass++;
        n_checks++;
        #2;
        cpu_rst = 1'b1;
        #1;
        if (uart_txd !== 1'b1) $display("FAIL rst_async_txd: got %b want 1", uart_txd); else n_pass++;
        n_checks++;
        bus_read(A_ST, rd);
        if (rd !== 32'h4) $display("FAIL rst_mid_status: got %h want 00000004", rd); else n_pass++;
        n_checks++;
        bus_read(A_BAUD, rd);
        if (rd !== 32'd434) $display("FAIL rst_mid_baud: got %0d want 434", rd); else n_pass++;
        n_checks++;
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        high_bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge cpu_clk);
            if (uart_txd !== 1'b1) high_bad++;
        end
        if (high_bad !== 0) $display("FAIL rst_byte_lost: %0d low cycles want 0", high_bad); else n_pass++;
        n_checks++;
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_overflow();
        test_back_to_back();
        test_divisor();
        test_random();
        test_parity();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
